spi_miso_frame_receiver: RTL

Receive-side companion to the SPI_SCLK generator on the ADS131A0X link. It samples SPI_MISO on the SCLK sampling edge while chip-select is active and deserializes MSB-first into WORD_BITS words. Each completed word is presented with a one-cycle valid strobe, and the block flags frame completion or truncation. It runs entirely in the system_clock domain and treats SPI_SCLK, SPI_CS_n and SPI_MISO as sampled pin-level inputs.

---
 rtl/spi_miso_frame_receiver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/spi_miso_frame_receiver.sv
// Deserializes SPI MISO into MSB-first words framed by CS_n, entirely in the
// system_clock domain; the SPI pins are treated as asynchronous level inputs.
module spi_miso_frame_receiver #(
  parameter int WORD_BITS       = 16,
  parameter int WORDS_PER_FRAME = 2,
  parameter int SAMPLE_ON_FALL  = 1
) (
  input  logic                 system_clock,
  input  logic                 reset_n,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_CS_n,
  input  logic                 SPI_MISO,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  output logic [7:0]           word_index,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CW = $clog2(WORD_BITS);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WORD_BITS - 1);
  localparam logic [7:0]    LAST_INDEX = 8'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t               state_reg;
  logic                 sclk_s1_reg, sclk_s2_reg, sclk_s3_reg;
  logic                 cs_s1_reg, cs_s2_reg, cs_s3_reg;
  logic                 miso_s1_reg, miso_s2_reg, miso_d_reg;
  logic                 sample_edge_reg, cs_fall_reg, cs_rise_reg;
  logic [1:0]           fill_reg;
  logic                 armed_reg;
  logic [CW-1:0]        bit_count_reg;
  logic [WORD_BITS-1:0] shift_reg;
  logic [WORD_BITS-1:0] new_word;
  logic                 sclk_edge;

  assign new_word  = {shift_reg[WORD_BITS-2:0], miso_d_reg};
  assign sclk_edge = (SAMPLE_ON_FALL != 0) ? (sclk_s3_reg & ~sclk_s2_reg)
                                           : (~sclk_s3_reg & sclk_s2_reg);
  assign busy      = (state_reg == ACTIVE);

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      sclk_s1_reg     <= 1'b0;
      sclk_s2_reg     <= 1'b0;
      sclk_s3_reg     <= 1'b0;
      cs_s1_reg       <= 1'b1;
      cs_s2_reg       <= 1'b1;
      cs_s3_reg       <= 1'b1;
      miso_s1_reg     <= 1'b0;
      miso_s2_reg     <= 1'b0;
      miso_d_reg      <= 1'b0;
      sample_edge_reg <= 1'b0;
      cs_fall_reg     <= 1'b0;
      cs_rise_reg     <= 1'b0;
      fill_reg        <= 2'd0;
      armed_reg       <= 1'b0;
      bit_count_reg   <= '0;
      shift_reg       <= '0;
      state_reg       <= IDLE;
      word_data       <= '0;
      word_valid      <= 1'b0;
      word_index      <= 8'd0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      sclk_s1_reg     <= SPI_SCLK;
      sclk_s2_reg     <= sclk_s1_reg;
      sclk_s3_reg     <= sclk_s2_reg;
      cs_s1_reg       <= SPI_CS_n;
      cs_s2_reg       <= cs_s1_reg;
      cs_s3_reg       <= cs_s2_reg;
      miso_s1_reg     <= SPI_MISO;
      miso_s2_reg     <= miso_s1_reg;
      miso_d_reg      <= miso_s2_reg;
      sample_edge_reg <= sclk_edge;
      cs_fall_reg     <= cs_s3_reg & ~cs_s2_reg;
      cs_rise_reg     <= ~cs_s3_reg & cs_s2_reg;

      // A frame may only start once CS_n has been seen genuinely high after
      // reset, so a CS_n held low through reset never opens a frame.
      if (fill_reg != 2'd3)
        fill_reg <= fill_reg + 2'd1;
      else if (cs_s2_reg && cs_s3_reg)
        armed_reg <= 1'b1;

      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cs_fall_reg && armed_reg) begin
            state_reg     <= ACTIVE;
            bit_count_reg <= '0;
            word_index    <= 8'd0;
            shift_reg     <= '0;
          end
        end
        ACTIVE: begin
          if (word_valid)
            word_index <= word_index + 8'd1;
          if (sample_edge_reg) begin
            shift_reg <= new_word;
            if (bit_count_reg == LAST_BIT) begin
              bit_count_reg <= '0;
              if (word_index == LAST_INDEX) begin
                word_data  <= new_word;
                word_valid <= 1'b1;
                frame_done <= 1'b1;
                state_reg  <= cs_rise_reg ? IDLE : DONE;
              end else if (cs_rise_reg) begin
                frame_error <= 1'b1;
                state_reg   <= IDLE;
              end else begin
                word_data  <= new_word;
                word_valid <= 1'b1;
              end
            end else begin
              bit_count_reg <= bit_count_reg + CW'(1);
              if (cs_rise_reg) begin
                frame_error <= 1'b1;
                state_reg   <= IDLE;
              end
            end
          end else if (cs_rise_reg) begin
            frame_error <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        DONE: begin
          if (cs_rise_reg)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
